// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings: key/collision/apple
// inputs on one side, game status, move tick, score and apple request on the other.
interface snake_game_ctrl_if;
    logic       key_start;
    logic       hit_wall;
    logic       hit_body;
    logic       apple_eaten;
    logic       apple_ack;
    logic [1:0] game_status;
    logic       move_tick;
    logic       apple_req;
    logic [7:0] score;
    logic       die_flash;

    modport master (
        output key_start, hit_wall, hit_body, apple_eaten, apple_ack,
        input  game_status, move_tick, apple_req, score, die_flash
    );

    modport slave (
        input  key_start, hit_wall, hit_body, apple_eaten, apple_ack,
        output game_status, move_tick, apple_req, score, die_flash
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: RESTART/START/PLAY/DIE state machine, move tick, saturating score,
// die blink and the apple-regeneration request/ack handshake. All outputs are registered.
module snake_game_ctrl #(
    parameter int unsigned TICK_DIV    = 12_500_000,
    parameter int unsigned RESTART_CYC = 16,
    parameter int unsigned DIE_CYC     = 50_000_000,
    parameter int unsigned FLASH_DIV   = 6_250_000
) (
    input logic              clk,
    input logic              rst_n,
    snake_game_ctrl_if.slave bus
);

    localparam int unsigned MAX_A   = (TICK_DIV > RESTART_CYC) ? TICK_DIV : RESTART_CYC;
    localparam int unsigned CNT_MAX = (MAX_A > DIE_CYC) ? MAX_A : DIE_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 2);
    localparam int unsigned FW      = $clog2(FLASH_DIV + 1);

    localparam logic [CW-1:0] TICK_LAST    = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] RESTART_LAST = CW'(RESTART_CYC - 1);
    localparam logic [CW-1:0] DIE_LAST     = CW'(DIE_CYC);
    localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_DIV - 1);

    typedef enum logic [1:0] {
        StRestart = 2'b00,
        StStart   = 2'b01,
        StPlay    = 2'b10,
        StDie     = 2'b11
    } state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_fcnt;
    logic            r_move_tick;
    logic            r_apple_req;
    logic [7:0]      r_score;
    logic            r_die_flash;

    logic            w_hit;
    logic            w_ack_clr;

    assign w_hit     = bus.hit_wall | bus.hit_body;
    assign w_ack_clr = r_apple_req & bus.apple_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRestart;
            r_cnt       <= '0;
            r_fcnt      <= '0;
            r_move_tick <= 1'b0;
            r_apple_req <= 1'b0;
            r_score     <= 8'd0;
            r_die_flash <= 1'b0;
        end else begin
            r_move_tick <= 1'b0;
            if (w_ack_clr) begin
                r_apple_req <= 1'b0;
            end
            case (r_state)
                StRestart: begin
                    r_score     <= 8'd0;
                    r_die_flash <= 1'b0;
                    // Initial apple for the new game; overrides a coincident ack.
                    if (r_cnt == '0) begin
                        r_apple_req <= 1'b1;
                    end
                    if (r_cnt == RESTART_LAST) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StStart: begin
                    if (bus.key_start) begin
                        r_state <= StPlay;
                        r_cnt   <= '0;
                    end
                end
                StPlay: begin
                    if (w_hit) begin
                        r_state     <= StDie;
                        r_cnt       <= '0;
                        r_fcnt      <= '0;
                        r_die_flash <= 1'b0;
                    end else begin
                        if (r_cnt == TICK_LAST) begin
                            r_cnt       <= '0;
                            r_move_tick <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (bus.apple_eaten) begin
                            if (r_score != 8'hFF) begin
                                r_score <= r_score + 8'd1;
                            end
                            if (!r_apple_req) begin
                                r_apple_req <= 1'b1;
                            end
                        end
                    end
                end
                StDie: begin
                    // r_cnt saturates at DIE_CYC; reaching it ends the lockout.
                    if (r_cnt != DIE_LAST) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (r_cnt == DIE_LAST && bus.key_start) begin
                        r_state     <= StRestart;
                        r_cnt       <= '0;
                        r_fcnt      <= '0;
                        r_die_flash <= 1'b0;
                        r_score     <= 8'd0;
                    end else if (r_fcnt == FLASH_LAST) begin
                        r_fcnt      <= '0;
                        r_die_flash <= ~r_die_flash;
                    end else begin
                        r_fcnt <= r_fcnt + FW'(1);
                    end
                end
                default: begin
                    r_state <= StRestart;
                end
            endcase
        end
    end

    assign bus.game_status = r_state;
    assign bus.move_tick   = r_move_tick;
    assign bus.apple_req   = r_apple_req;
    assign bus.score       = r_score;
    assign bus.die_flash   = r_die_flash;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with small timing parameters and hand-computed
// expectations; outputs are sampled 1 ns after each rising edge.
module tb_snake_game_ctrl;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   flash_exp [7] = '{0, 0, 1, 1, 0, 0, 1};

    snake_game_ctrl_if bus ();

    snake_game_ctrl #(
        .TICK_DIV    (4),
        .RESTART_CYC (3),
        .DIE_CYC     (5),
        .FLASH_DIV   (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total = n_total + 1;
        if (got != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_status"}, int'(bus.game_status), 0);
        check({tag, "_req"}, int'(bus.apple_req), 0);
        check({tag, "_score"}, int'(bus.score), 0);
        check({tag, "_tick"}, int'(bus.move_tick), 0);
        check({tag, "_flash"}, int'(bus.die_flash), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total         = 0;
        n_bad           = 0;
        rst_n           = 1'b0;
        bus.key_start   = 1'b0;
        bus.hit_wall    = 1'b0;
        bus.hit_body    = 1'b0;
        bus.apple_eaten = 1'b0;
        bus.apple_ack   = 1'b0;
        tick();
        tick();
        check_all_reset("rst");

        // Leave reset: three cycles of RESTART, then START.
        rst_n = 1'b1;
        check("restart_c0", int'(bus.game_status), 0);
        tick();
        check("restart_c1", int'(bus.game_status), 0);
        check("init_req", int'(bus.apple_req), 1);
        tick();
        check("restart_c2", int'(bus.game_status), 0);
        tick();
        check("to_start", int'(bus.game_status), 1);
        check("req_held", int'(bus.apple_req), 1);
        bus.apple_ack = 1'b1;
        tick();
        bus.apple_ack = 1'b0;
        check("req_acked", int'(bus.apple_req), 0);
        check("score0", int'(bus.score), 0);

        // Enter PLAY; move_tick every 4th cycle.
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        check("to_play", int'(bus.game_status), 2);
        check("tick_entry", int'(bus.move_tick), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("tick_%0d", i), int'(bus.move_tick), (i % 4 == 0) ? 1 : 0);
        end

        // Three apples, each with its own request/ack pair.
        for (int a = 1; a <= 3; a++) begin
            bus.apple_eaten = 1'b1;
            tick();
            bus.apple_eaten = 1'b0;
            check($sformatf("score_%0d", a), int'(bus.score), a);
            check($sformatf("req_on_%0d", a), int'(bus.apple_req), 1);
            bus.apple_ack = 1'b1;
            tick();
            bus.apple_ack = 1'b0;
            check($sformatf("req_off_%0d", a), int'(bus.apple_req), 0);
        end

        // Second apple while a request is pending is counted but not re-queued.
        bus.apple_eaten = 1'b1;
        tick();
        bus.apple_eaten = 1'b0;
        check("rq_score4", int'(bus.score), 4);
        tick();
        bus.apple_eaten = 1'b1;
        tick();
        bus.apple_eaten = 1'b0;
        check("rq_score5", int'(bus.score), 5);
        check("rq_req", int'(bus.apple_req), 1);
        bus.apple_ack = 1'b1;
        tick();
        bus.apple_ack = 1'b0;
        check("rq_acked", int'(bus.apple_req), 0);
        tick();
        check("rq_no_requeue", int'(bus.apple_req), 0);

        // Hit with simultaneous apple: DIE, score and request untouched.
        bus.hit_body    = 1'b1;
        bus.apple_eaten = 1'b1;
        tick();
        bus.hit_body    = 1'b0;
        bus.apple_eaten = 1'b0;
        check("die_status", int'(bus.game_status), 3);
        check("die_score", int'(bus.score), 5);
        check("die_req", int'(bus.apple_req), 0);

        // DIE: early key ignored, flash pattern, key after lockout restarts.
        for (int k = 0; k <= 5; k++) begin
            check($sformatf("flash_%0d", k), int'(bus.die_flash), flash_exp[k]);
            check($sformatf("die_st_%0d", k), int'(bus.game_status), 3);
            check($sformatf("die_tick_%0d", k), int'(bus.move_tick), 0);
            bus.key_start = (k == 2);
            tick();
            bus.key_start = 1'b0;
        end
        check("flash_6", int'(bus.die_flash), flash_exp[6]);
        check("die_st_6", int'(bus.game_status), 3);
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        check("re_status", int'(bus.game_status), 0);
        check("re_score", int'(bus.score), 0);
        check("re_flash", int'(bus.die_flash), 0);

        tick();
        tick();
        tick();
        check("re_start", int'(bus.game_status), 1);
        check("re_req", int'(bus.apple_req), 1);
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        check("re_play", int'(bus.game_status), 2);

        // 300 apples with no acks: score saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            bus.apple_eaten = 1'b1;
            tick();
            bus.apple_eaten = 1'b0;
            if (i == 254) check("sat_254", int'(bus.score), 254);
            if (i == 255) check("sat_255", int'(bus.score), 255);
            tick();
        end
        check("sat_end", int'(bus.score), 255);
        check("sat_req", int'(bus.apple_req), 1);
        check("sat_status", int'(bus.game_status), 2);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_reset("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_status", int'(bus.game_status), 0);
        check("post_rst_req", int'(bus.apple_req), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
